// File: rtl/bet_pkg.sv
// Shared definitions for the bet ledger and the keyboard-to-bet decoder.
package bet_pkg;

   // Control opcodes at the default 6-bit opcode width
   localparam logic [5:0] SPIN_OP_DEF = 6'b111110;
   localparam logic [5:0] NOP_OP_DEF  = 6'b111111;

   // Bet opcodes produced by the keyboard-to-bet decoder
   localparam logic [5:0] OP_STRAIGHT_0 = 6'd0;
   localparam logic [5:0] OP_STRAIGHT_36 = 6'd36;
   localparam logic [5:0] OP_RED        = 6'd37;
   localparam logic [5:0] OP_BLACK      = 6'd38;
   localparam logic [5:0] OP_EVEN       = 6'd39;
   localparam logic [5:0] OP_ODD        = 6'd40;
   localparam logic [5:0] OP_LOW        = 6'd41;
   localparam logic [5:0] OP_HIGH       = 6'd42;

   // Ledger FSM: OPEN takes bets, LOCKED holds them through a spin, CLEAR wipes
   typedef enum logic [1:0] {
      ST_OPEN   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_CLEAR  = 2'd2
   } bet_state_e;

   // Stored entry is {colour tag, opcode}
   function automatic int entry_w(input int colw, input int opw);
      return colw + opw;
   endfunction

endpackage

// File: rtl/bet_skip_filter.sv
// Drops the duplicate key events that follow each considered keypress.
module bet_skip_filter #(
   parameter int SKIP = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   input  logic rx_valid,
   output logic considered
);

   logic [2:0] skip_cnt;

   // An event is only looked at once the previous keypress's duplicates are gone
   assign considered = enable && rx_valid && (skip_cnt == 3'd0);

   // Count down duplicates; reload after every considered event; frozen while disabled
   always_ff @(posedge clock) begin
      if (reset || clear)
         skip_cnt <= 3'd0;
      else if (enable && rx_valid)
         skip_cnt <= (skip_cnt != 3'd0) ? skip_cnt - 3'd1 : 3'(SKIP);
   end

endmodule

// File: rtl/bet_ledger.sv
// Bet recorder: captures colour-tagged opcodes, locks during a spin, clears after.
module bet_ledger
   import bet_pkg::*;
#(
   parameter int             SLOTS   = 12,
   parameter int             OPW     = 6,
   parameter int             COLW    = 2,
   parameter int             SKIP    = 1,
   parameter logic [OPW-1:0] SPIN_OP = {{(OPW-1){1'b1}}, 1'b0},
   parameter logic [OPW-1:0] NOP_OP  = {OPW{1'b1}}
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               rx_valid,
   input  logic [OPW-1:0]                     rx_opcode,
   input  logic [2:0]                         color,
   input  logic                               spin_done,
   input  logic [5:0]                         rd_idx,
   output logic [entry_w(COLW, OPW)-1:0]       rd_data,
   output logic [SLOTS*entry_w(COLW, OPW)-1:0] bets_flat,
   output logic [5:0]                         count,
   output logic                               full,
   output logic                               spin_start,
   output logic                               locked
);

   localparam int EW = entry_w(COLW, OPW);

   bet_state_e    state;
   logic          considered;
   logic          clear;
   logic          is_spin;
   logic          is_nop;
   logic          wr_en;
   logic          spin_req;
   logic [EW-1:0] entry;
   logic [EW-1:0] slot_q [SLOTS];

   assign clear    = (state == ST_CLEAR);
   assign locked   = (state != ST_OPEN);
   assign full     = (count == 6'(SLOTS));
   assign is_spin  = (rx_opcode == SPIN_OP);
   assign is_nop   = (rx_opcode == NOP_OP);
   assign entry    = {color[COLW-1:0], rx_opcode};
   // A bet needs a chip on the sensor and a free slot; control opcodes never store
   assign wr_en    = considered && !is_spin && !is_nop && (color != 3'd0) && !full;
   // A spin on an empty bank is meaningless and is ignored
   assign spin_req = considered && is_spin && (count != 6'd0);

   bet_skip_filter #(.SKIP(SKIP)) u_skip (
      .clock      (clock),
      .reset      (reset),
      .enable     (state == ST_OPEN),
      .clear      (clear),
      .rx_valid   (rx_valid),
      .considered (considered)
   );

   // Round sequencing and the registered spin grant pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_OPEN;
         spin_start <= 1'b0;
      end else begin
         spin_start <= spin_req;
         unique case (state)
            ST_OPEN:   if (spin_req)  state <= ST_LOCKED;
            ST_LOCKED: if (spin_done) state <= ST_CLEAR;
            ST_CLEAR:                 state <= ST_OPEN;
            default:                  state <= ST_OPEN;
         endcase
      end
   end

   // Occupancy doubles as the next write pointer; slots fill in order, no wrap
   always_ff @(posedge clock) begin
      if (reset || clear)
         count <= 6'd0;
      else if (wr_en)
         count <= count + 6'd1;
   end

   for (genvar g = 0; g < SLOTS; g++) begin : g_slot
      // Write-once slot: loaded only when it is the next free position
      always_ff @(posedge clock) begin
         if (reset || clear)
            slot_q[g] <= '0;
         else if (wr_en && (count == 6'(g)))
            slot_q[g] <= entry;
      end
      assign bets_flat[g*EW +: EW] = slot_q[g];
   end

   // Indexed readout; out-of-range indices read as zero
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < SLOTS; i++)
         if (rd_idx == 6'(i)) rd_data = slot_q[i];
   end

endmodule

// File: tb/tb_bet_ledger.sv
// Directed bench: default ledger driven from a vector table, small ledger by hand.
module tb_bet_ledger;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   // Default instance (12 slots, skip 1)
   logic        a_reset, a_rx_valid, a_spin_done;
   logic [5:0]  a_rx_opcode, a_rd_idx, a_count;
   logic [2:0]  a_color;
   logic [7:0]  a_rd_data;
   logic [95:0] a_bets_flat;
   logic        a_full, a_spin_start, a_locked;

   // Small instance (4 slots, skip 0)
   logic        b_reset, b_rx_valid, b_spin_done;
   logic [5:0]  b_rx_opcode, b_rd_idx, b_count;
   logic [2:0]  b_color;
   logic [7:0]  b_rd_data;
   logic [31:0] b_bets_flat;
   logic        b_full, b_spin_start, b_locked;

   bet_ledger dut_a (
      .clock(clock), .reset(a_reset), .rx_valid(a_rx_valid), .rx_opcode(a_rx_opcode),
      .color(a_color), .spin_done(a_spin_done), .rd_idx(a_rd_idx), .rd_data(a_rd_data),
      .bets_flat(a_bets_flat), .count(a_count), .full(a_full),
      .spin_start(a_spin_start), .locked(a_locked)
   );

   bet_ledger #(.SLOTS(4), .SKIP(0)) dut_b (
      .clock(clock), .reset(b_reset), .rx_valid(b_rx_valid), .rx_opcode(b_rx_opcode),
      .color(b_color), .spin_done(b_spin_done), .rd_idx(b_rd_idx), .rd_data(b_rd_data),
      .bets_flat(b_bets_flat), .count(b_count), .full(b_full),
      .spin_start(b_spin_start), .locked(b_locked)
   );

   typedef struct {
      logic        v;
      logic [5:0]  op;
      logic [2:0]  col;
      logic        sd;
      logic [5:0]  cnt;
      logic        ss;
      logic        lk;
      logic [23:0] flat;   // expected slots 0..2; higher slots stay zero
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [5:0] op, input logic [2:0] col,
                      input logic sd, input logic [5:0] cnt, input logic ss,
                      input logic lk, input logic [23:0] flat);
      vec_t r;
      r.v = v; r.op = op; r.col = col; r.sd = sd;
      r.cnt = cnt; r.ss = ss; r.lk = lk; r.flat = flat;
      tbl.push_back(r);
   endtask

   task automatic b_bet(input logic [5:0] op, input logic [2:0] col);
      b_rx_valid = 1'b1; b_rx_opcode = op; b_color = col;
      @(posedge clock); #1;
      b_rx_valid = 1'b0;
   endtask

   initial begin
      logic [23:0] ef;
      a_reset = 1'b1; a_rx_valid = 1'b0; a_rx_opcode = '0; a_color = '0;
      a_spin_done = 1'b0; a_rd_idx = 6'd1;
      b_reset = 1'b1; b_rx_valid = 1'b0; b_rx_opcode = '0; b_color = '0;
      b_spin_done = 1'b0; b_rd_idx = 6'd0;

      //   v  op     col  sd  cnt ss lk  slots 2..0
      add(1, 6'd5,  3'd2, 0, 6'd1, 0, 0, 24'h000085);
      add(1, 6'd5,  3'd2, 0, 6'd1, 0, 0, 24'h000085); // duplicate skipped
      add(1, 6'd9,  3'd2, 0, 6'd2, 0, 0, 24'h008985);
      add(1, 6'd9,  3'd2, 0, 6'd2, 0, 0, 24'h008985);
      add(1, 6'd12, 3'd2, 0, 6'd3, 0, 0, 24'h8C8985);
      add(1, 6'd12, 3'd2, 0, 6'd3, 0, 0, 24'h8C8985);
      add(0, 6'd0,  3'd0, 1, 6'd3, 0, 0, 24'h8C8985); // spin_done in OPEN ignored
      add(1, 6'd62, 3'd2, 0, 6'd3, 1, 1, 24'h8C8985); // spin granted
      add(0, 6'd0,  3'd0, 0, 6'd3, 0, 1, 24'h8C8985); // pulse is one cycle
      add(1, 6'd7,  3'd1, 0, 6'd3, 0, 1, 24'h8C8985); // locked: bet ignored
      add(0, 6'd0,  3'd0, 1, 6'd3, 0, 1, 24'h8C8985); // spin_done -> CLEAR
      add(0, 6'd0,  3'd0, 0, 6'd0, 0, 0, 24'h000000); // wiped, OPEN again
      add(1, 6'd62, 3'd2, 0, 6'd0, 0, 0, 24'h000000); // spin on empty bank ignored
      add(1, 6'd62, 3'd2, 0, 6'd0, 0, 0, 24'h000000);
      add(1, 6'd7,  3'd0, 0, 6'd0, 0, 0, 24'h000000); // no chip: dropped
      add(1, 6'd7,  3'd0, 0, 6'd0, 0, 0, 24'h000000); // its duplicate still skipped
      add(1, 6'd7,  3'd1, 0, 6'd1, 0, 0, 24'h000047);
      add(1, 6'd7,  3'd1, 0, 6'd1, 0, 0, 24'h000047);
      add(1, 6'd63, 3'd2, 0, 6'd1, 0, 0, 24'h000047); // NOP still loads skip
      add(1, 6'd5,  3'd2, 0, 6'd1, 0, 0, 24'h000047); // ...so this is skipped
      add(1, 6'd62, 3'd1, 0, 6'd1, 1, 1, 24'h000047);
      add(1, 6'd5,  3'd1, 0, 6'd1, 0, 1, 24'h000047);
      add(0, 6'd0,  3'd0, 1, 6'd1, 0, 1, 24'h000047);
      add(0, 6'd0,  3'd0, 0, 6'd0, 0, 0, 24'h000000);
      add(1, 6'd3,  3'd3, 0, 6'd1, 0, 0, 24'h0000C3); // next bet lands in slot 0

      repeat (2) @(posedge clock);
      #1;
      a_reset = 1'b0; b_reset = 1'b0;
      chk("reset count",     a_count, 6'd0);
      chk("reset locked",    a_locked, 1'b0);
      chk("reset spin",      a_spin_start, 1'b0);
      chk("reset full",      a_full, 1'b0);
      chk("reset bets_flat", a_bets_flat, 96'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         a_rx_valid = tbl[i].v; a_rx_opcode = tbl[i].op;
         a_color = tbl[i].col; a_spin_done = tbl[i].sd;
         @(posedge clock); #1;
         ef = tbl[i].flat;
         chk($sformatf("row%0d count", i),  a_count, tbl[i].cnt);
         chk($sformatf("row%0d spin", i),   a_spin_start, tbl[i].ss);
         chk($sformatf("row%0d locked", i), a_locked, tbl[i].lk);
         chk($sformatf("row%0d full", i),   a_full, 1'b0);
         chk($sformatf("row%0d flat", i),   a_bets_flat, {72'd0, ef});
         chk($sformatf("row%0d rd1", i),    a_rd_data, ef[15:8]);
      end
      a_rx_valid = 1'b0; a_spin_done = 1'b0;
      a_rd_idx = 6'd0;  #1 chk("a rd slot0", a_rd_data, 8'hC3);
      a_rd_idx = 6'd12; #1 chk("a rd oob",   a_rd_data, 8'h00);

      // Small bank: fills, saturates, then drops
      for (int k = 0; k < 6; k++) begin
         b_bet(6'(k + 1), 3'd3);
         chk($sformatf("b bet%0d count", k), b_count, (k < 4) ? 6'(k + 1) : 6'd4);
         chk($sformatf("b bet%0d full", k),  b_full, (k >= 3) ? 1'b1 : 1'b0);
      end
      chk("b flat", b_bets_flat, 32'hC4C3C2C1);
      b_rd_idx = 6'd5; #1 chk("b rd oob",   b_rd_data, 8'h00);
      b_rd_idx = 6'd3; #1 chk("b rd slot3", b_rd_data, 8'hC4);

      // Spin, then reset while locked with a spin_done on the same edge
      b_bet(6'd62, 3'd3);
      chk("b spin_start", b_spin_start, 1'b1);
      chk("b locked",     b_locked, 1'b1);
      b_reset = 1'b1; b_spin_done = 1'b1;
      @(posedge clock); #1;
      b_reset = 1'b0; b_spin_done = 1'b0;
      chk("b rst count",  b_count, 6'd0);
      chk("b rst locked", b_locked, 1'b0);
      chk("b rst spin",   b_spin_start, 1'b0);
      chk("b rst full",   b_full, 1'b0);
      chk("b rst flat",   b_bets_flat, 32'd0);
      b_bet(6'd9, 3'd1);
      chk("b post-rst bet", b_bets_flat, 32'h00000049);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
